lcd_write_sequencer: RTL and testbench
======================================

Name: lcd_write_sequencer

Overview:
- Owns the character-LCD bus: lcd_data, lcd_en, lcd_rs and lcd_rw.
- After reset, runs the fixed HD44780 power-up/init command sequence.
- Then serves byte writes from two requesters: requester 0 is the operand/number display path, requester 1 is the status/result path.
- Arbitration is round-robin over valid/ready handshakes; the block generates all EN pulse timing, so requesters only present bytes.

Parameters:
- EN_HIGH_CYC, 25000, cycles lcd_en is held high per write (0.5 ms at 50 MHz).
- EN_LOW_CYC, 25000, cycles lcd_en is held low after the pulse before the next write.
- POWERUP_CYC, 750000, idle cycles after reset before the first init command (15 ms).
- CLEAR_EXTRA_CYC, 100000, extra low-time after clear/home commands (optional feature only).
- CNT_W, 32, width of the shared timing counter; must hold the largest cycle parameter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_rs  in  1  0 = command, 1 = character
- req0_data  in  8  byte to write
- req0_ready  out  1  requester 0 byte accepted this cycle when valid
- req1_valid, req1_rs, req1_data, req1_ready  as requester 0
- lcd_data  out  8  LCD data bus
- lcd_en  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0 (write only)
- init_done  out  1  init sequence complete
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - lcd_data=0x00, lcd_en=0, lcd_rs=0, lcd_rw=0.
  - init_done=0, busy=1, both ready=0.
  - Counter=0, init index=0, last_grant=1, state=PWRUP.
- Reset mid-operation aborts any pulse, forces lcd_en=0 immediately and reruns the full init sequence.
- States: PWRUP, SETUP, EN_HI, EN_LO, IDLE.
- PWRUP: count POWERUP_CYC cycles, then load init byte 0 and go to SETUP.
- Init ROM (rs=0, in order): 0x38, 0x0C, 0x06, 0x01, 0x80.
- SETUP (1 cycle): lcd_data/lcd_rs drive the latched byte; lcd_en=0 (address setup).
- EN_HI: lcd_en=1 for exactly EN_HIGH_CYC cycles; lcd_data/lcd_rs stable.
- EN_LO: lcd_en=0 for EN_LOW_CYC cycles (plus extra, see Optional Feature); lcd_data/lcd_rs stay stable throughout. On expiry:
  - Init index < 4: increment index, load next ROM byte, go to SETUP.
  - Init index = 4: set init_done=1 (sticky until reset), go to IDLE.
  - Otherwise: go to IDLE.
- IDLE: busy=0.
  - A ready is asserted only in IDLE with init_done=1, and only to the granted requester.
  - Grant rule: if only one requester is valid, it is granted. If both are valid, grant the one not equal to last_grant.
  - Accept = valid & ready in cycle N. In cycle N: latch data/rs, update last_grant, enter SETUP at N+1.
  - lcd_en rises at N+2.
  - Next accept is possible at N+2+EN_HIGH_CYC+EN_LOW_CYC at the earliest.
- Requests raised during init or a pulse wait; they are never dropped. Requester valid must not depend on ready; ready may depend on both valids combinationally.
- Counter compares use terminal value (param-1); counter clears on every state change.
- After acceptance, the requester may drop or change its data; the block uses only latched copies.

Optional Feature:
- Macro: LCD_CLEAR_LONG_WAIT_EN.
- Defined: any write with rs=0 and data 0x01 or 0x02 (init clear included) holds EN_LO for EN_LOW_CYC+CLEAR_EXTRA_CYC cycles.
- Undefined: every write uses EN_LOW_CYC only, and CLEAR_EXTRA_CYC is unused.

Decomposition:
- Package lcd_pkg:
  - Command constants: CMD_FUNC_SET_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_LINE0=0x80, CHR_SPACE=0x20.
  - State encoding and init-ROM length (5).
- Sub-module lcd_rr_arbiter2: two valids plus last_grant in, one-hot grant out; purely combinational, instantiated once.

Test Plan:
All scenarios use EN_HIGH_CYC=4, EN_LOW_CYC=3, POWERUP_CYC=10, CLEAR_EXTRA_CYC=20.
1. Release reset, no requests. Expect:
   - lcd_en stays 0 for 10 cycles.
   - Exactly five EN pulses of 4 cycles with lcd_rs=0 and data 0x38, 0x0C, 0x06, 0x01, 0x80.
   - init_done rises after the last low-time.
2. After init, req0 sends rs=1, 0x41 and is held valid. Expect:
   - req0_ready for one cycle.
   - lcd_data=0x41 and lcd_rs=1 one cycle before lcd_en rises; lcd_en high 4 cycles.
   - Next ready 9 cycles after the accept.
3. Both requesters valid continuously (req0 0x30, req1 0x31). Expect:
   - Grants alternate req0, req1, req0, req1.
   - lcd_data sequence 0x30, 0x31, 0x30, 0x31.
4. req1 valid during init. Expect req1_ready=0 until init_done; its byte is then the first post-init write.
5. Assert rst while lcd_en=1 in the second write. Expect lcd_en=0 asynchronously, init_done=0, and the full init sequence repeats.
6. With LCD_CLEAR_LONG_WAIT_EN, req0 sends rs=0, 0x01. Expect low-time of 23 cycles; with rs=1, 0x01, expect low-time of 3 cycles. Without the macro, expect 3 cycles in both cases.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD command constants, FSM state encoding and the HD44780 init ROM.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON       = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC     = 8'h06;
    localparam logic [7:0] CMD_CLEAR         = 8'h01;
    localparam logic [7:0] CMD_HOME          = 8'h02;
    localparam logic [7:0] CMD_LINE0         = 8'h80;
    localparam logic [7:0] CHR_SPACE         = 8'h20;

    localparam int INIT_LEN = 5;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EN_HI,
        ST_EN_LO,
        ST_IDLE
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_FUNC_SET_8B2L;
            3'd1:    return CMD_DISP_ON;
            3'd2:    return CMD_ENTRY_INC;
            3'd3:    return CMD_CLEAR;
            default: return CMD_LINE0;
        endcase
    endfunction

    // Clear and home are the slow HD44780 commands.
    function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, the requester not served last wins a tie.
// Latency: purely combinational. Backpressure: none; a grant only names who may be accepted.
// last_grant: 0 = requester 0 was served last, 1 = requester 1 was served last.
module lcd_rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && valid[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Character-LCD bus owner: HD44780 power-up init, then round-robin byte writes from two requesters.
// Latency: accept in N, setup at N+1, lcd_en high from N+2; next accept >= N+2+EN_HIGH_CYC+EN_LOW_CYC.
// Backpressure: ready only in IDLE after init; LCD_CLEAR_LONG_WAIT_EN stretches clear/home low-time.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_HIGH_CYC     = 25000,
    parameter int unsigned EN_LOW_CYC      = 25000,
    parameter int unsigned POWERUP_CYC     = 750000,
    parameter int unsigned CLEAR_EXTRA_CYC = 100000,
    parameter int          CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       init_done,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PWR_TERM  = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] HI_TERM   = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LO_TERM   = CNT_W'(EN_LOW_CYC - 1);
    localparam logic [2:0]       INIT_LAST = 3'(INIT_LEN - 1);

    lcd_state_t       state;
    lcd_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lo_term;
    logic [2:0]       init_idx;
    logic             last_grant;
    lcd_byte_t        cur;
    lcd_byte_t        req_sel;
    logic [1:0]       grant;
    logic             idle_open;
    logic             accept;
    logic             pwr_done;
    logic             hi_done;
    logic             lo_done;

    lcd_rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign idle_open  = (state == ST_IDLE) && init_done;
    assign req0_ready = idle_open && grant[0];
    assign req1_ready = idle_open && grant[1];
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        req_sel = '{rs: req0_rs, data: req0_data};
        if (grant[1]) begin
            req_sel = '{rs: req1_rs, data: req1_data};
        end
    end

`ifdef LCD_CLEAR_LONG_WAIT_EN
    localparam logic [CNT_W-1:0] LO_LONG_TERM = CNT_W'(EN_LOW_CYC + CLEAR_EXTRA_CYC - 1);

    assign lo_term = is_clear_cmd(cur.rs, cur.data) ? LO_LONG_TERM : LO_TERM;
`else
    logic unused_clear_extra;

    assign unused_clear_extra = ^(CNT_W'(CLEAR_EXTRA_CYC));
    assign lo_term            = LO_TERM;
`endif

    assign pwr_done = (cnt == PWR_TERM);
    assign hi_done  = (cnt == HI_TERM);
    assign lo_done  = (cnt == lo_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PWRUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PWRUP: if (pwr_done) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_EN_HI;
            ST_EN_HI: if (hi_done) state_nxt = ST_EN_LO;
            ST_EN_LO: begin
                if (lo_done) begin
                    state_nxt = (!init_done && init_idx < INIT_LAST) ? ST_SETUP : ST_IDLE;
                end
            end
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            default:  state_nxt = ST_PWRUP;
        endcase
    end

    // One shared counter, restarted on every state change and parked at zero in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            init_idx   <= '0;
            init_done  <= 1'b0;
            last_grant <= 1'b1;
            cur        <= '0;
        end else begin
            cnt <= (state_nxt != state || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);

            if (state == ST_PWRUP && pwr_done) begin
                cur <= '{rs: 1'b0, data: init_rom(3'd0)};
            end

            if (state == ST_EN_LO && lo_done && !init_done) begin
                if (init_idx < INIT_LAST) begin
                    init_idx <= init_idx + 3'd1;
                    cur      <= '{rs: 1'b0, data: init_rom(init_idx + 3'd1)};
                end else begin
                    init_done <= 1'b1;
                end
            end

            if (accept) begin
                cur        <= req_sel;
                last_grant <= grant[1];
            end
        end
    end

    assign lcd_data = cur.data;
    assign lcd_rs   = cur.rs;
    assign lcd_en   = (state == ST_EN_HI);
    assign lcd_rw   = 1'b0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with short timing parameters.
module tb_lcd_write_sequencer;

    localparam int EN_HI = 4;
    localparam int EN_LO = 3;
    localparam int PWR   = 10;
    localparam int CLR_X = 20;
`ifdef LCD_CLEAR_LONG_WAIT_EN
    localparam int CLR_LO = EN_LO + CLR_X;
`else
    localparam int CLR_LO = EN_LO;
`endif

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rs, lcd_rw, init_done, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] init_bytes [5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};

    lcd_write_sequencer #(
        .EN_HIGH_CYC     (EN_HI),
        .EN_LOW_CYC      (EN_LO),
        .POWERUP_CYC     (PWR),
        .CLEAR_EXTRA_CYC (CLR_X),
        .CNT_W           (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_data   (lcd_data),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .init_done  (init_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples and input changes happen on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_rise(input int bound, output int n, output logic [7:0] pd, output logic pr);
        n  = 0;
        pd = lcd_data;
        pr = lcd_rs;
        while (lcd_en !== 1'b1 && n < bound) begin
            pd = lcd_data;
            pr = lcd_rs;
            step();
            n++;
        end
        if (lcd_en !== 1'b1) n = -1;
    endtask

    task automatic measure_pulse(output int hi);
        hi = 0;
        while (lcd_en === 1'b1 && hi < 100) begin
            step();
            hi++;
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic run_write_lowtime(input logic rs, input logic [7:0] d, output int lo);
        int n, hi;
        logic [7:0] pd;
        logic pr;
        req0_valid = 1'b1; req0_rs = rs; req0_data = d;
        #1;
        n = 0;
        while (req0_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        step();
        req0_valid = 1'b0;
        wait_rise(20, n, pd, pr);
        measure_pulse(hi);
        wait_idle(100, lo);
    endtask

    task automatic test_reset();
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 0", lcd_data); end
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b expected 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b expected 0", lcd_rw); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++; $display("FAIL rst_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Entered at the falling edge where reset is released.
    task automatic test_init_sequence();
        int n, hi, gap;
        logic [7:0] pd;
        logic pr;
        wait_rise(50, n, pd, pr);
        checks++; if (n !== PWR + 1) begin errors++; $display("FAIL init_pwrup_wait: got %0d expected %0d", n, PWR + 1); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                gap = (init_bytes[i-1] == 8'h01) ? CLR_LO + 1 : EN_LO + 1;
                wait_rise(60, n, pd, pr);
                checks++; if (n !== gap) begin errors++; $display("FAIL init_gap[%0d]: got %0d expected %0d", i, n, gap); end
            end
            checks++; if (pd !== init_bytes[i] || pr !== 1'b0) begin
                errors++; $display("FAIL init_setup[%0d]: got %0h/%b expected %0h/0", i, pd, pr, init_bytes[i]);
            end
            checks++; if (lcd_data !== init_bytes[i] || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
                errors++; $display("FAIL init_data[%0d]: got %0h/%b expected %0h/0", i, lcd_data, lcd_rs, init_bytes[i]);
            end
            measure_pulse(hi);
            checks++; if (hi !== EN_HI) begin errors++; $display("FAIL init_hi[%0d]: got %0d expected %0d", i, hi, EN_HI); end
        end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b expected 0", init_done); end
        n = 0;
        while (init_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++; if (n !== EN_LO) begin errors++; $display("FAIL init_done_delay: got %0d expected %0d", n, EN_LO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_init();
        step();
        rst = 1'b0;
        test_init_sequence();
    endtask

    task automatic test_single_write();
        int k, hi;
        logic data_ok;
        step();
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready});
        end
        step();
        checks++; if (req0_ready !== 1'b0 || lcd_en !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_setup_ctl: got rdy %b en %b busy %b expected 0 0 1", req0_ready, lcd_en, busy);
        end
        checks++; if (lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin
            errors++; $display("FAIL single_setup_data: got %0h/%b expected 41/1", lcd_data, lcd_rs);
        end
        req0_data = 8'h5A; req0_rs = 1'b0;
        k = 1; hi = 0; data_ok = 1'b1;
        while (req0_ready !== 1'b1 && k < 30) begin
            step();
            k++;
            if (lcd_en === 1'b1) begin
                hi++;
                if (lcd_data !== 8'h41 || lcd_rs !== 1'b1) data_ok = 1'b0;
            end
        end
        checks++; if (hi !== EN_HI) begin errors++; $display("FAIL single_hi: got %0d expected %0d", hi, EN_HI); end
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL single_latched: got %b expected 1", data_ok); end
        checks++; if (k !== 9) begin errors++; $display("FAIL single_next_ready: got %0d expected 9", k); end
        req0_valid = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", req0_ready); end
    endtask

    task automatic test_req_during_init();
        int n, rises, hi;
        logic seen, prev_en;
        logic [7:0] pd;
        logic pr;
        rst = 1'b1;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
        step();
        step();
        rst = 1'b0;
        seen = 1'b0; rises = 0; prev_en = 1'b0; n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            step();
            n++;
            if (init_done !== 1'b1 && req1_ready === 1'b1) seen = 1'b1;
            if (lcd_en === 1'b1 && prev_en === 1'b0) rises++;
            prev_en = lcd_en;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL dinit_ready_early: got %b expected 0", seen); end
        checks++; if (rises !== 5) begin errors++; $display("FAIL dinit_pulses: got %0d expected 5", rises); end
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL dinit_ready: got %b expected 10", {req1_ready, req0_ready});
        end
        step();
        req1_valid = 1'b0;
        checks++; if (lcd_data !== 8'h31 || lcd_rs !== 1'b1) begin
            errors++; $display("FAIL dinit_first_write: got %0h/%b expected 31/1", lcd_data, lcd_rs);
        end
        wait_rise(10, n, pd, pr);
        checks++; if (n !== 1) begin errors++; $display("FAIL dinit_rise: got %0d expected 1", n); end
        measure_pulse(hi);
        wait_idle(50, n);
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (g % 2 == 0) ? 8'h30 : 8'h31;
            checks++; if ({req1_ready, req0_ready} !== exp_g) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", g, {req1_ready, req0_ready}, exp_g);
            end
            if (g > 0) begin
                checks++; if (n !== 8) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 8", g, n); end
            end
            step();
            if (g == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            checks++; if (lcd_data !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %0h expected %0h", g, lcd_data, exp_d); end
        end
        wait_idle(50, n);
    endtask

    task automatic test_reset_mid_pulse();
        int n, hi;
        logic [7:0] pd;
        logic pr;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h42;
        #1;
        wait_rise(20, n, pd, pr);
        measure_pulse(hi);
        wait_rise(20, n, pd, pr);
        step();
        req0_valid = 1'b0;
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL rmid_en_before: got %b expected 1", lcd_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL rmid_en_async: got %b expected 0", lcd_en); end
        checks++; if (init_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rmid_status: got init_done %b busy %b expected 0 1", init_done, busy);
        end
        step();
        step();
        rst = 1'b0;
        test_init_sequence();
    endtask

    task automatic test_clear_wait();
        int lo;
        run_write_lowtime(1'b0, 8'h01, lo);
        checks++; if (lo !== CLR_LO) begin errors++; $display("FAIL clr_cmd_low: got %0d expected %0d", lo, CLR_LO); end
        run_write_lowtime(1'b1, 8'h01, lo);
        checks++; if (lo !== EN_LO) begin errors++; $display("FAIL clr_char_low: got %0d expected %0d", lo, EN_LO); end
        run_write_lowtime(1'b0, 8'h02, lo);
        checks++; if (lo !== CLR_LO) begin errors++; $display("FAIL home_cmd_low: got %0d expected %0d", lo, CLR_LO); end
        run_write_lowtime(1'b0, 8'h38, lo);
        checks++; if (lo !== EN_LO) begin errors++; $display("FAIL plain_cmd_low: got %0d expected %0d", lo, EN_LO); end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        test_reset();
        test_init();
        test_single_write();
        test_req_during_init();
        test_round_robin();
        test_reset_mid_pulse();
        test_clear_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
